// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU arbiter/sequencer: FSM encodings, ALU input-select
// codes, the one-hot opcode set understood by the ALU, and an opcode legality check.
package alu_ctrl_pkg;

  localparam int OP_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_WAIT = 2'b10,
    ST_RESP = 2'b11
  } state_t;

  // alu_in_sel is {persist, load, reset}
  localparam logic [2:0] IN_SEL_PERSIST = 3'b100;
  localparam logic [2:0] IN_SEL_LOAD    = 3'b010;
  localparam logic [2:0] IN_SEL_RESET   = 3'b001;

  localparam logic [OP_W-1:0] OP_ADD  = 7'b1000000;
  localparam logic [OP_W-1:0] OP_SUB  = 7'b0100000;
  localparam logic [OP_W-1:0] OP_AND  = 7'b0010000;
  localparam logic [OP_W-1:0] OP_OR   = 7'b0001000;
  localparam logic [OP_W-1:0] OP_XOR  = 7'b0000100;
  localparam logic [OP_W-1:0] OP_NOT  = 7'b0000010;
  localparam logic [OP_W-1:0] OP_PASS = 7'b0000001;

  function automatic logic is_onehot7(input logic [OP_W-1:0] op);
    logic [2:0] ones;
    ones = 3'd0;
    for (int i = 0; i < OP_W; i++) begin
      ones = ones + {2'b00, op[i]};
    end
    return ones == 3'd1;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Client-side request/response bus of the ALU arbiter. Both clients share one
// bundle; per-client fields are packed side by side, client i in slice i.
interface alu_arbiter_if #(
  parameter int W = 8
) ();
  import alu_ctrl_pkg::*;

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [2*OP_W-1:0] req_op;
  logic [2*W-1:0]    req_a;
  logic [2*W-1:0]    req_b;
  logic [1:0]        rsp_valid;
  logic [W-1:0]      rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins outright, a tie goes to the
// client that did not win last time. Purely combinational.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_g,
  output logic [1:0] gnt,
  output logic       g
);

  always_comb begin
    g = 1'b0;
    if (req == 2'b11) begin
      g = ~last_g;
    end else if (req[1]) begin
      g = 1'b1;
    end
    gnt = (req == 2'b00) ? 2'b00 : (g ? 2'b10 : 2'b01);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two clients onto the shared ALU, sequences load/wait/capture for the
// granted op and returns the result to the owner as a one-cycle response pulse.
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int ALU_LAT = 2,
  parameter int W       = 8
) (
  input  logic            clk,
  input  logic            rst,
  alu_arbiter_if.slave    bus,
  output logic            busy,
  output logic            alu_on,
  output logic [2:0]      alu_in_sel,
  output logic [W-1:0]    alu_num1,
  output logic [W-1:0]    alu_num2,
  output logic [OP_W-1:0] alu_out_sel,
  input  logic [W-1:0]    alu_out
);

  localparam logic [3:0] LAT_CNT = 4'(ALU_LAT);

  state_t          state_reg;
  state_t          state_next;
  logic            g_reg;
  logic            last_g_reg;
  logic [3:0]      cnt_reg;
  logic [W-1:0]    result_reg;
  logic            err_reg;
  logic [W-1:0]    num1_reg;
  logic [W-1:0]    num2_reg;
  logic [OP_W-1:0] sel_reg;

  logic [OP_W-1:0] op_arr [2];
  logic [W-1:0]    a_arr  [2];
  logic [W-1:0]    b_arr  [2];
  logic [1:0]      gnt;
  logic            g_pick;
  logic [1:0]      rsp_onehot;
  logic            any_req;
  logic            op_legal;

  for (genvar gi = 0; gi < 2; gi++) begin : g_client
    assign op_arr[gi]     = bus.req_op[OP_W*gi +: OP_W];
    assign a_arr[gi]      = bus.req_a[W*gi +: W];
    assign b_arr[gi]      = bus.req_b[W*gi +: W];
    assign rsp_onehot[gi] = (g_reg == 1'(gi));
  end

  rr_arb2 u_arb (
    .req    (bus.req_valid),
    .last_g (last_g_reg),
    .gnt    (gnt),
    .g      (g_pick)
  );

  assign any_req  = |bus.req_valid;
  assign op_legal = is_onehot7(op_arr[g_pick]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (any_req) state_next = op_legal ? ST_LOAD : ST_RESP;
      ST_LOAD: state_next = ST_WAIT;
      ST_WAIT: if (cnt_reg == 4'd0) state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // ALU operands are only written for legal ops, so an illegal request leaves
  // the ALU-facing registers exactly as the previous operation left them.
  always_ff @(posedge clk) begin
    if (rst) begin
      g_reg      <= 1'b0;
      last_g_reg <= 1'b1;
      cnt_reg    <= 4'd0;
      result_reg <= '0;
      err_reg    <= 1'b0;
      num1_reg   <= '0;
      num2_reg   <= '0;
      sel_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (any_req) begin
            g_reg      <= g_pick;
            err_reg    <= ~op_legal;
            result_reg <= '0;
            if (op_legal) begin
              num1_reg <= a_arr[g_pick];
              num2_reg <= b_arr[g_pick];
              sel_reg  <= op_arr[g_pick];
            end
          end
        end
        ST_LOAD: cnt_reg <= LAT_CNT;
        ST_WAIT: begin
          if (cnt_reg == 4'd0) begin
            result_reg <= alu_out;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        ST_RESP: last_g_reg <= g_reg;
        default: ;
      endcase
    end
  end

  // Outputs are forced to their reset values combinationally so they are clean
  // from the very first cycle rst is seen, even mid-operation.
  always_comb begin
    bus.req_ready = 2'b00;
    bus.rsp_valid = 2'b00;
    bus.rsp_data  = '0;
    bus.rsp_err   = 1'b0;
    busy          = 1'b0;
    alu_on        = 1'b0;
    alu_in_sel    = IN_SEL_RESET;
    alu_num1      = '0;
    alu_num2      = '0;
    alu_out_sel   = '0;
    if (!rst) begin
      alu_on      = 1'b1;
      busy        = (state_reg != ST_IDLE);
      alu_in_sel  = IN_SEL_PERSIST;
      alu_num1    = num1_reg;
      alu_num2    = num2_reg;
      alu_out_sel = sel_reg;
      case (state_reg)
        ST_IDLE: bus.req_ready = gnt;
        ST_LOAD: alu_in_sel = IN_SEL_LOAD;
        ST_RESP: begin
          bus.rsp_valid = rsp_onehot;
          bus.rsp_data  = err_reg ? '0 : result_reg;
          bus.rsp_err   = err_reg;
        end
        default: ;
      endcase
    end
  end

endmodule
